// File: rtl/tc_pu_acc.sv
// Tensor-core processing unit with per-lane tile accumulation.
// N_UNIT lanes share one A vector and each takes its own B vector. Every
// accepted beat forms an N_MUL-element dot product per lane. The dot products
// are accumulated until the beat flagged in_last closes the tile. The closed
// tile is then shifted, clamped and presented on a valid/ready output.
module tc_pu_acc #(
  parameter int N_UNIT = 4,
  parameter int N_MUL  = 4,
  parameter int DW_MUL = 8,
  parameter int DW_ADD = 32,
  parameter int DW_OUT = 16,
  parameter int SHIFT  = 0,
  parameter int CW     = 8,
  localparam int DW_UNIT_IN = DW_MUL * N_MUL
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW_UNIT_IN-1:0]        in_a,
  input  logic [N_UNIT*DW_UNIT_IN-1:0] in_b,
  input  logic                         in_last,
  input  logic                         in_signed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_UNIT*DW_OUT-1:0]     out,
  output logic [N_UNIT-1:0]            out_ovf,
  output logic [CW-1:0]                out_cnt
);

  localparam int NP = N_UNIT * N_MUL;
  localparam int PW = 2 * DW_MUL;

  typedef enum logic {IDLE, ACCUM} state_t;

  // Element product. Operands are widened by one bit so that a single signed
  // multiplier covers both modes; the low PW bits hold the exact product
  // in either interpretation.
  function automatic logic [PW-1:0] mul_elem(input logic [DW_MUL-1:0] a,
                                             input logic [DW_MUL-1:0] b,
                                             input logic              sgn);
    logic signed [DW_MUL:0] ax;
    logic signed [DW_MUL:0] bx;
    logic signed [PW-1:0]   p;
    ax = $signed({sgn & a[DW_MUL-1], a});
    bx = $signed({sgn & b[DW_MUL-1], b});
    p  = ax * bx;
    return p;
  endfunction

  // Extends a product to accumulator width according to the tile mode.
  function automatic logic signed [DW_ADD-1:0] ext_prod(input logic [PW-1:0] p,
                                                        input logic          sgn);
    return $signed({{(DW_ADD-PW){sgn & p[PW-1]}}, p});
  endfunction

  // Shift and clamp an accumulator into the output range.
  // Returns {overflow_flag, value}.
  function automatic logic [DW_OUT:0] shift_sat(input logic signed [DW_ADD-1:0] acc,
                                                input logic                     sgn);
    logic [DW_ADD-1:0] r;
    logic [DW_OUT-1:0] v;
    logic              ovf;
    if (sgn) begin
      r   = $unsigned(acc >>> SHIFT);
      ovf = !((&r[DW_ADD-1:DW_OUT-1]) || !(|r[DW_ADD-1:DW_OUT-1]));
      if (ovf) v = r[DW_ADD-1] ? {1'b1, {(DW_OUT-1){1'b0}}} : {1'b0, {(DW_OUT-1){1'b1}}};
      else     v = r[DW_OUT-1:0];
    end else begin
      r   = $unsigned(acc) >> SHIFT;
      ovf = |r[DW_ADD-1:DW_OUT];
      v   = ovf ? {DW_OUT{1'b1}} : r[DW_OUT-1:0];
    end
    return {ovf, v};
  endfunction

  // Input-side tile tracking: the mode of a tile is fixed by its first beat.
  logic                     open_p0;
  logic                     tmode_p0;
  logic                     beat_sgn;
  logic                     take;
  logic                     stall;
  logic [PW-1:0]            prod_c [NP];

  // Stage 1 registers
  logic                     vld_p1;
  logic                     last_p1;
  logic                     sgn_p1;
  logic [PW-1:0]            prod_p1 [NP];
  logic signed [DW_ADD-1:0] sum_p1 [N_UNIT];
  logic                     adv_p1;

  // Stage 2 accumulator state
  state_t                   state_q, state_d;
  logic signed [DW_ADD-1:0] acc_p2 [N_UNIT];
  logic signed [DW_ADD-1:0] acc_d  [N_UNIT];
  logic [CW-1:0]            cnt_p2, cnt_d;
  logic                     mode_p2, mode_d;
  logic                     res_load;
  logic                     res_sgn;
  logic [N_UNIT*DW_OUT-1:0] res_out;
  logic [N_UNIT-1:0]        res_ovf;

  assign stall    = vld_p1 & last_p1 & out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign take     = in_valid & in_ready;
  assign beat_sgn = open_p0 ? tmode_p0 : in_signed;
  assign adv_p1   = vld_p1 & ~stall;

  // Element-wise products of the incoming beat.
  always_comb begin
    for (int i = 0; i < N_UNIT; i++) begin
      for (int j = 0; j < N_MUL; j++) begin
        prod_c[i*N_MUL+j] = mul_elem(in_a[DW_MUL*j +: DW_MUL],
                                     in_b[DW_UNIT_IN*i + DW_MUL*j +: DW_MUL],
                                     beat_sgn);
      end
    end
  end

  // Stage 0 -> 1: capture products of an accepted beat; hold while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      open_p0  <= 1'b0;
      tmode_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      sgn_p1   <= 1'b0;
      for (int k = 0; k < NP; k++) prod_p1[k] <= '0;
    end else if (!stall) begin
      vld_p1 <= take;
      if (take) begin
        open_p0 <= ~in_last;
        if (!open_p0) tmode_p0 <= in_signed;
        last_p1 <= in_last;
        sgn_p1  <= beat_sgn;
        prod_p1 <= prod_c;
      end
    end
  end

  // Per-lane reduction of the stage-1 products.
  always_comb begin
    for (int i = 0; i < N_UNIT; i++) begin
      sum_p1[i] = '0;
      for (int j = 0; j < N_MUL; j++) begin
        sum_p1[i] = sum_p1[i] + ext_prod(prod_p1[i*N_MUL+j], sgn_p1);
      end
    end
  end

  // Tile FSM next state: load or accumulate, and close the tile on last.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_p2;
    cnt_d    = cnt_p2;
    mode_d   = mode_p2;
    res_load = 1'b0;
    res_sgn  = mode_p2;
    if (adv_p1) begin
      if (state_q == IDLE) begin
        for (int i = 0; i < N_UNIT; i++) acc_d[i] = sum_p1[i];
        cnt_d   = CW'(1);
        mode_d  = sgn_p1;
        res_sgn = sgn_p1;
      end else begin
        for (int i = 0; i < N_UNIT; i++) acc_d[i] = acc_p2[i] + sum_p1[i];
        cnt_d = cnt_p2 + {{(CW-1){1'b0}}, ~&cnt_p2};
      end
      if (last_p1) begin
        res_load = 1'b1;
        state_d  = IDLE;
      end else begin
        state_d  = ACCUM;
      end
    end
  end

  // Output formation from the closing accumulator values.
  always_comb begin
    logic [DW_OUT:0] s;
    res_out = '0;
    res_ovf = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      s = shift_sat(acc_d[i], res_sgn);
      res_out[DW_OUT*i +: DW_OUT] = s[DW_OUT-1:0];
      res_ovf[i] = s[DW_OUT];
    end
  end

  // Stage 1 -> 2: accumulator, beat counter, tile mode and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_p2  <= '0;
      mode_p2 <= 1'b0;
      for (int i = 0; i < N_UNIT; i++) acc_p2[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_p2  <= cnt_d;
      mode_p2 <= mode_d;
      acc_p2  <= acc_d;
    end
  end

  // Stage 2 -> output: load a closed tile; drop valid once consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_ovf   <= '0;
      out_cnt   <= '0;
    end else if (res_load) begin
      out_valid <= 1'b1;
      out       <= res_out;
      out_ovf   <= res_ovf;
      out_cnt   <= cnt_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tc_pu_acc.sv
// Directed bench for tc_pu_acc: a table of single-tile vectors plus hand-written
// stall and mid-tile reset sequences. A second instance uses SHIFT=4.
module tb_tc_pu_acc;

  localparam int NU  = 4;
  localparam int NM  = 4;
  localparam int DM  = 8;
  localparam int DO  = 16;
  localparam int CWB = 8;
  localparam int AW  = DM * NM;
  localparam int BW  = NU * AW;
  localparam int OW  = NU * DO;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;

  logic           in_ready, out_valid;
  logic [OW-1:0]  out;
  logic [NU-1:0]  out_ovf;
  logic [CWB-1:0] out_cnt;
  logic           in_ready2, out_valid2;
  logic [OW-1:0]  out2;
  logic [NU-1:0]  out_ovf2;
  logic [CWB-1:0] out_cnt2;

  always #5 clk = ~clk;

  tc_pu_acc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  tc_pu_acc #(.SHIFT(4)) dut_s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_signed(in_signed),
    .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
    .out_ovf(out_ovf2), .out_cnt(out_cnt2)
  );

  typedef struct {
    logic [AW-1:0]  a;
    logic [BW-1:0]  b;
    logic           sgn;
    int             nb;
    logic           gap;
    logic [OW-1:0]  eo;
    logic [NU-1:0]  eovf;
    logic [CWB-1:0] ecnt;
    logic           chk2;
    logic [OW-1:0]  eo2;
    logic [NU-1:0]  eovf2;
  } vec_t;

  vec_t vecs [6];
  vec_t hv;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one tile; later beats flip in_signed, which must be ignored.
  task automatic run_tile(input vec_t v, input string tag);
    for (int k = 0; k < v.nb; k++) begin
      in_valid  = 1'b1;
      in_a      = v.a;
      in_b      = v.b;
      in_last   = (k == v.nb - 1);
      in_signed = (k == 0) ? v.sgn : ~v.sgn;
      tick();
      if (v.gap && k != v.nb - 1) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"},   out,       v.eo);
    check({tag, "_ovf"},   out_ovf,   v.eovf);
    check({tag, "_cnt"},   out_cnt,   v.ecnt);
    if (v.chk2) begin
      check({tag, "_s4_valid"}, out_valid2, 1);
      check({tag, "_s4_out"},   out2,       v.eo2);
      check({tag, "_s4_ovf"},   out_ovf2,   v.eovf2);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // unsigned a=[1,2,3,4]; lanes 10, 6, 0, 100
    vecs[0] = '{32'h04030201, {32'h0A0A0A0A, 32'h0, 32'h01000002, 32'h01010101}, 1'b0, 1, 1'b0,
                {16'd100, 16'd0, 16'd6, 16'd10}, 4'h0, 8'd1,
                1'b1, {16'd6, 16'd0, 16'd0, 16'd0}, 4'h0};
    // signed -128*-128, 4 beats: acc 262144 clamps high
    vecs[1] = '{32'h80808080, {4{32'h80808080}}, 1'b1, 4, 1'b0,
                {4{16'h7FFF}}, 4'hF, 8'd4,
                1'b1, {4{16'h4000}}, 4'h0};
    // unsigned 255*255: acc 260100 clamps at 65535; >>4 gives 16256
    vecs[2] = '{32'hFFFFFFFF, {4{32'hFFFFFFFF}}, 1'b0, 1, 1'b0,
                {4{16'hFFFF}}, 4'hF, 8'd1,
                1'b1, {4{16'd16256}}, 4'h0};
    // signed mode kept from the first beat, bubble between beats: -10, 6, 0, -10
    vecs[3] = '{32'h000000FF, {32'h00000005, 32'h0, 32'h000000FD, 32'h00000005}, 1'b1, 2, 1'b1,
                {16'hFFF6, 16'h0000, 16'h0006, 16'hFFF6}, 4'h0, 8'd2,
                1'b1, {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF}, 4'h0};
    // signed -128*127: acc -65024 clamps low; >>>4 gives -4064
    vecs[4] = '{32'h80808080, {4{32'h7F7F7F7F}}, 1'b1, 1, 1'b0,
                {4{16'h8000}}, 4'hF, 8'd1,
                1'b1, {4{16'hF020}}, 4'h0};
    // 300-beat tile: counter saturates at 255
    vecs[5] = '{32'h0, {4{32'h0}}, 1'b0, 300, 1'b0,
                {4{16'h0}}, 4'h0, 8'd255,
                1'b0, {4{16'h0}}, 4'h0};

    // Reset state
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_out",   out,       0);
    check("rst_ovf",   out_ovf,   0);
    check("rst_cnt",   out_cnt,   0);
    check("rst_ready", in_ready,  1);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_tile(vecs[i], $sformatf("vec%0d", i));
    end
    tick();

    // Back-pressure: two 1-beat tiles, then a third beat offered while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h00000001;
    in_b      = {4{32'h00000007}};
    in_last   = 1'b1;
    in_signed = 1'b0;
    tick();
    check("stall_ready_pre", in_ready, 1);
    in_b = {4{32'h00000009}};
    tick();
    in_b = {4{32'h0000000B}};
    check("stall_valid",   out_valid, 1);
    check("stall_out_a",   out,       {4{16'd7}});
    check("stall_ready0",  in_ready,  0);
    tick();
    tick();
    check("stall_hold_out", out,      {4{16'd7}});
    check("stall_hold_cnt", out_cnt,  1);
    check("stall_ready1",   in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stall_b_valid", out_valid, 1);
    check("stall_b_out",   out,       {4{16'd9}});
    tick();
    check("stall_c_valid", out_valid, 1);
    check("stall_c_out",   out,       {4{16'd11}});
    tick();
    check("stall_drain", out_valid, 0);

    // Reset in the middle of a tile discards the partial sum
    in_valid  = 1'b1;
    in_a      = 32'h00000001;
    in_b      = {4{32'd100}};
    in_last   = 1'b0;
    in_signed = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_out",   out,       0);
    check("mrst_ovf",   out_ovf,   0);
    check("mrst_cnt",   out_cnt,   0);
    tick();
    reset = 1'b1;
    tick();
    hv = '{32'h00000001, {4{32'h00000003}}, 1'b0, 1, 1'b0,
           {4{16'd3}}, 4'h0, 8'd1, 1'b0, {4{16'h0}}, 4'h0};
    run_tile(hv, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
